// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-port responder.
// Frames are a 32-bit header (command byte + 24-bit address) followed by 32 data bits.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_WR_DATA,
        ST_RD_LOAD,
        ST_RD_DATA,
        ST_SKIP
    } spi_state_t;

    localparam int CMD_W     = 8;
    localparam int ADDR_W    = 24;
    localparam int DATA_W    = 32;
    localparam int HDR_BITS  = 32;
    localparam int DATA_BITS = 32;
    localparam int CNT_W     = 6;

    localparam logic [CMD_W-1:0] CMD_WRITE_DEF = 8'h69;
    localparam logic [CMD_W-1:0] CMD_READ_DEF  = 8'h00;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin with rise/fall detection
// taken from the last two flops; edges are visible STAGES cycles after the pin moves.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {(STAGES + 1){RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-1:0], i_d};
        end
    end

    assign o_rise = r_chain[STAGES-1] & ~r_chain[STAGES];
    assign o_fall = ~r_chain[STAGES-1] & r_chain[STAGES];

endmodule

// File: rtl/spi_slave_regif.sv
// SPI responder: decodes LSB-first command/address headers and turns them into
// single-cycle register-port write/read strobes, returning read data on miso.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for cs_n falling; miso tri-stated (oe=0, miso=0)
// ST_HEADER  | shifting in 8-bit command + 24-bit address
// ST_WR_DATA | shifting in 32 write-data bits
// ST_RD_LOAD | rd_en issued; capture rd_data the following cycle
// ST_RD_DATA | driving 32 read-data bits on miso
// ST_SKIP    | unknown command; counting out the data phase silently
module spi_slave_regif
    import spi_pkg::*;
#(
    parameter logic [CMD_W-1:0] CMD_WRITE   = CMD_WRITE_DEF,
    parameter logic [CMD_W-1:0] CMD_READ    = CMD_READ_DEF,
    parameter int               SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              cmd_err,
    output logic              frame_done
);

    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic w_mosi, w_abort, w_last, w_hdr_done, w_done;
    logic [HDR_BITS-1:0] w_rx_next;
    spi_state_t w_state_nxt;

    spi_state_t          r_state;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [HDR_BITS-1:0] r_rx_sr;
    logic [DATA_W-1:0]   r_tx_sr;
    logic                r_rd_armed;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_wr_en, r_rd_en, r_cmd_err, r_frame_done;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .i_d(sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .i_d(cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    // Same depth as the sclk chain so mosi is aligned with the detected edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_rx_next  = {w_mosi, r_rx_sr[HDR_BITS-1:1]};
    assign w_abort    = (r_state != ST_IDLE) && w_cs_rise;
    assign w_last     = w_sclk_rise && (r_bit_cnt == CNT_W'(HDR_BITS - 1));
    assign w_hdr_done = !w_abort && w_last && (r_state == ST_HEADER);
    assign w_done     = !w_abort && w_last &&
                        ((r_state == ST_WR_DATA) || (r_state == ST_RD_DATA) || (r_state == ST_SKIP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (w_cs_fall) w_state_nxt = ST_HEADER;
                ST_HEADER: begin
                    if (w_last) begin
                        if (w_rx_next[CMD_W-1:0] == CMD_WRITE)     w_state_nxt = ST_WR_DATA;
                        else if (w_rx_next[CMD_W-1:0] == CMD_READ) w_state_nxt = ST_RD_LOAD;
                        else                                       w_state_nxt = ST_SKIP;
                    end
                end
                ST_RD_LOAD: if (!r_rd_en) w_state_nxt = ST_RD_DATA;
                ST_WR_DATA, ST_RD_DATA, ST_SKIP: if (w_last) w_state_nxt = ST_IDLE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_rx_sr      <= '0;
            r_tx_sr      <= '0;
            r_rd_armed   <= 1'b0;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_frame_done <= 1'b0;

            if (w_state_nxt != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_sclk_rise && (r_state != ST_IDLE) && (r_state != ST_RD_LOAD)) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end

            if (w_sclk_rise && ((r_state == ST_HEADER) || (r_state == ST_WR_DATA))) begin
                r_rx_sr <= w_rx_next;
            end

            if (w_hdr_done) begin
                r_addr    <= w_rx_next[HDR_BITS-1:CMD_W];
                r_rd_en   <= (w_state_nxt == ST_RD_LOAD);
                r_cmd_err <= (w_state_nxt == ST_SKIP);
            end

            if (w_done) begin
                r_frame_done <= 1'b1;
                if (r_state == ST_WR_DATA) begin
                    r_wr_en   <= 1'b1;
                    r_wr_data <= w_rx_next;
                end
            end

            // The falling edge between the last header bit and the first data
            // rise must not shift, so shifting is armed by the first data rise.
            if ((r_state == ST_RD_LOAD) && !r_rd_en) begin
                r_tx_sr    <= rd_data;
                r_rd_armed <= 1'b0;
            end else if (r_state == ST_RD_DATA) begin
                if (w_sclk_rise) r_rd_armed <= 1'b1;
                if (w_sclk_fall && r_rd_armed) r_tx_sr <= {1'b0, r_tx_sr[DATA_W-1:1]};
            end
        end
    end

    assign miso_oe    = (r_state == ST_RD_DATA) && !w_cs_rise;
    assign miso       = miso_oe & r_tx_sr[0];
    assign addr       = r_addr;
    assign wr_en      = r_wr_en;
    assign wr_data    = r_wr_data;
    assign rd_en      = r_rd_en;
    assign cmd_err    = r_cmd_err;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Bench for spi_slave_regif: bit-banged SPI master, frame-level reference model,
// directed scenarios followed by randomized frames.
module tb_spi_slave_regif;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, sclk, cs_n, mosi;
    logic        miso, miso_oe, wr_en, rd_en, cmd_err, frame_done;
    logic [23:0] addr;
    logic [31:0] wr_data, rd_data;

    int n_checks = 0, n_errors = 0;
    int mon_wr = 0, mon_rd = 0, mon_err = 0, mon_fd = 0, width_bad = 0;
    int exp_wr = 0, exp_rd = 0, exp_err = 0, exp_fd = 0;
    logic [55:0] wr_q[$], exp_wr_q[$];
    logic [23:0] rd_q[$], exp_rd_q[$];
    logic [23:0] exp_addr = '0;
    logic [31:0] rd_val = '0;
    logic prev_wr = 1'b0, prev_rd = 1'b0, prev_err = 1'b0, prev_fd = 1'b0;

    always #5 clk = ~clk;

    spi_slave_regif dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .cmd_err(cmd_err), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Observed port activity
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin mon_wr++; wr_q.push_back({addr, wr_data}); end
        if (rd_en === 1'b1) begin mon_rd++; rd_q.push_back(addr); end
        if (cmd_err === 1'b1) mon_err++;
        if (frame_done === 1'b1) mon_fd++;
        if ((wr_en & prev_wr) | (rd_en & prev_rd) | (cmd_err & prev_err) | (frame_done & prev_fd))
            width_bad++;
        prev_wr = wr_en; prev_rd = rd_en; prev_err = cmd_err; prev_fd = frame_done;
    end

    // Register port: valid read data only during the cycle after rd_en.
    initial begin
        rd_data = $urandom;
        forever begin
            @(negedge clk);
            if (rd_en === 1'b1) begin
                @(posedge clk); #1 rd_data = rd_val;
                @(posedge clk); #1 rd_data = $urandom;
            end
        end
    end

    // Reference model: outcome of one frame given how many bits were clocked.
    task automatic model_frame(input logic [7:0] cmd, input logic [23:0] a,
                               input logic [31:0] d, input int nbits);
        if (nbits >= 32) begin
            exp_addr = a;
            if (cmd == 8'h00) begin exp_rd++; exp_rd_q.push_back(a); end
            else if (cmd != 8'h69) exp_err++;
        end
        if (nbits == 64) begin
            exp_fd++;
            if (cmd == 8'h69) begin exp_wr++; exp_wr_q.push_back({a, d}); end
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [23:0] a, input logic [31:0] d,
                             input int nbits, input int half, input bit raise_cs, input int extra);
        logic [63:0] bits;
        logic [31:0] mword;
        int oe_bad;
        bit is_rd;
        bits = {d, a, cmd};
        mword = '0;
        oe_bad = 0;
        is_rd = (cmd == 8'h00);
        cs_n = 1'b0;
        wait_clk(half);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0; mosi = bits[i];
            wait_clk(half);
            if (miso_oe !== ((i >= 32) && is_rd)) oe_bad++;
            if (i >= 32) mword[i-32] = miso;
            sclk = 1'b1;
            wait_clk(half);
        end
        for (int i = 0; i < extra; i++) begin
            sclk = 1'b0; mosi = 1'($urandom);
            wait_clk(half);
            sclk = 1'b1;
            wait_clk(half);
        end
        chk("miso_oe_phase", 64'(oe_bad), 64'd0);
        if (is_rd && nbits == 64) chk("rd_miso_word", 64'(mword), 64'(rd_val));
        if (raise_cs) begin
            cs_n = 1'b1;
            wait_clk(2 * half);
        end
    endtask

    task automatic verify(input string tag);
        wait_clk(12);
        chk({tag, "_wr_cnt"}, 64'(mon_wr), 64'(exp_wr));
        chk({tag, "_rd_cnt"}, 64'(mon_rd), 64'(exp_rd));
        chk({tag, "_err_cnt"}, 64'(mon_err), 64'(exp_err));
        chk({tag, "_fd_cnt"}, 64'(mon_fd), 64'(exp_fd));
        chk({tag, "_addr"}, 64'(addr), 64'(exp_addr));
        while (wr_q.size() > 0 && exp_wr_q.size() > 0)
            chk({tag, "_wr_word"}, 64'(wr_q.pop_front()), 64'(exp_wr_q.pop_front()));
        while (rd_q.size() > 0 && exp_rd_q.size() > 0)
            chk({tag, "_rd_addr"}, 64'(rd_q.pop_front()), 64'(exp_rd_q.pop_front()));
        wr_q.delete(); exp_wr_q.delete(); rd_q.delete(); exp_rd_q.delete();
    endtask

    task automatic frame_and_model(input logic [7:0] cmd, input logic [23:0] a, input logic [31:0] d,
                                   input int nbits, input int half, input int extra);
        model_frame(cmd, a, d, nbits);
        run_frame(cmd, a, d, nbits, half, 1'b1, extra);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; sclk = 1'b1; cs_n = 1'b1; mosi = 1'b0;
        wait_clk(5);
        chk("rst_ctrl", 64'({miso, miso_oe, wr_en, rd_en, cmd_err, frame_done}), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        rst_n = 1'b1;
        wait_clk(5);

        frame_and_model(8'h69, 24'h00A5C3, 32'hDEADBEEF, 64, 6, 0);
        verify("write");

        rd_val = 32'h12345678;
        frame_and_model(8'h00, 24'h000010, 32'h0, 64, 6, 0);
        verify("read");

        frame_and_model(8'h3C, 24'h123456, 32'hCAFEF00D, 64, 6, 0);
        verify("unknown");

        frame_and_model(8'h69, 24'h0BEEF0, 32'hFFFF0000, 52, 6, 0);
        verify("abort");
        chk("abort_idle", 64'(dut.r_state), 64'(ST_IDLE));
        frame_and_model(8'h69, 24'h0BEEF1, 32'h00000001, 64, 6, 0);
        verify("after_abort");

        repeat (4) begin
            sclk = 1'b0; mosi = 1'($urandom);
            wait_clk(6);
            sclk = 1'b1;
            wait_clk(6);
        end
        verify("idle_sclk");

        rd_val = $urandom;
        model_frame(8'h00, 24'h00CC33, 32'h0, 40);
        run_frame(8'h00, 24'h00CC33, 32'h0, 40, 6, 1'b0, 0);
        chk("rst_pre_oe", 64'(miso_oe), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", 64'({miso_oe, miso}), 64'd0);
        chk("rst_mid_strobes", 64'({wr_en, rd_en, cmd_err, frame_done}), 64'd0);
        chk("rst_mid_addr", 64'(addr), 64'd0);
        exp_addr = '0;
        cs_n = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        verify("reset");
        rd_val = 32'hA5A50FF0;
        frame_and_model(8'h00, 24'h000777, 32'h0, 64, 6, 0);
        verify("read_after_rst");

        frame_and_model(8'h69, 24'h111111, 32'h01234567, 64, 5, 0);
        frame_and_model(8'h69, 24'h222222, 32'h89ABCDEF, 64, 5, 0);
        verify("b2b");

        for (int f = 0; f < 10; f++) begin
            logic [7:0] c;
            case ($urandom_range(0, 2))
                0:       c = 8'h69;
                1:       c = 8'h00;
                default: c = 8'($urandom);
            endcase
            rd_val = $urandom;
            frame_and_model(c, 24'($urandom), $urandom, 64, int'($urandom_range(5, 8)),
                            int'($urandom_range(0, 2)));
            verify("rand");
        end

        chk("strobe_width", 64'(width_bad), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
